pl_tx_arbiter: RTL and testbench

- Transmit-side scheduler that shares the 512-bit physical-layer symbol path between two packet requesters: TLP and DLLP.
- Grants one requester per packet and holds the grant until that packet's last beat.
- Drives beats through a single registered output stage with valid/ready backpressure toward the packet identifier (out_valid feeds valid_pd).
- Discards in-flight packets when the link drops, and counts the drops.

---
 rtl/pl_tx_arbiter_if.sv | 15 +
 rtl/pl_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_pl_tx_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pl_tx_arbiter_if.sv
// Beat stream bundle shared by the two requesters and the output toward the
// packet identifier. The master drives the beat and the slave returns ready.
interface pl_tx_arbiter_if #(
  parameter int DATA_W = 512,
  parameter int DK_W   = 64
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic [DK_W-1:0]   dk;
  logic              last;
  logic              ready;

  modport master (output valid, data, dk, last, input ready);
  modport slave  (input valid, data, dk, last, output ready);
endinterface

// File: rtl/pl_tx_arbiter.sv
// Transmit-side scheduler: shares the 512-bit symbol path between TLP and
// DLLP requesters, one packet per grant, through a single registered output
// stage. Packets caught by link loss are drained and counted in drop_cnt.
module pl_tx_arbiter #(
  parameter int DATA_W       = 512,
  parameter int DK_W         = 64,
  parameter int MAX_DLLP_RUN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   linkup,
  pl_tx_arbiter_if.slave         tlp,
  pl_tx_arbiter_if.slave         dllp,
  pl_tx_arbiter_if.master        out,
  output logic [1:0]             grant,
  output logic [7:0]             drop_cnt
);

  localparam int RUN_W = $clog2(MAX_DLLP_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DLLP_RUN);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GNT_TLP    = 3'd1,
    GNT_DLLP   = 3'd2,
    FLUSH_TLP  = 3'd3,
    FLUSH_DLLP = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [RUN_W-1:0]  run_reg, run_next;
  logic [7:0]        drop_cnt_reg;
  logic              drop_inc;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [DK_W-1:0]   out_dk_reg;
  logic              out_last_reg;

  logic              tlp_rdy;
  logic              dllp_rdy;
  logic              load_en;
  logic              load_dllp;

  // Owner can accept a new beat whenever the output register is empty or
  // is being emptied this cycle.
  logic              stage_free;
  assign stage_free = !out_valid_reg || out.ready;

  // Arbitration, ready generation, packet tracking and drop detection.
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    drop_inc   = 1'b0;
    tlp_rdy    = 1'b0;
    dllp_rdy   = 1'b0;
    load_en    = 1'b0;
    load_dllp  = 1'b0;

    case (state_reg)
      IDLE: begin
        // DLLPs win until they have taken MAX_DLLP_RUN grants in a row with
        // a TLP waiting; then the TLP gets one packet and the run restarts.
        if (linkup) begin
          if (dllp.valid && ((run_reg < RUN_MAX) || !tlp.valid)) begin
            state_next = GNT_DLLP;
            if (run_reg != RUN_MAX) begin
              run_next = run_reg + 1'b1;
            end
          end else if (tlp.valid) begin
            state_next = GNT_TLP;
            run_next   = '0;
          end
        end
      end

      GNT_TLP: begin
        tlp_rdy = linkup ? stage_free : 1'b1;
        if (tlp.valid && tlp_rdy) begin
          if (linkup) begin
            load_en = 1'b1;
            if (tlp.last) begin
              state_next = IDLE;
            end
          end else if (tlp.last) begin
            state_next = IDLE;
            drop_inc   = 1'b1;
          end else begin
            state_next = FLUSH_TLP;
          end
        end
      end

      GNT_DLLP: begin
        dllp_rdy = linkup ? stage_free : 1'b1;
        if (dllp.valid && dllp_rdy) begin
          if (linkup) begin
            load_en   = 1'b1;
            load_dllp = 1'b1;
            if (dllp.last) begin
              state_next = IDLE;
            end
          end else if (dllp.last) begin
            state_next = IDLE;
            drop_inc   = 1'b1;
          end else begin
            state_next = FLUSH_DLLP;
          end
        end
      end

      FLUSH_TLP: begin
        // Drain the abandoned packet regardless of link state.
        tlp_rdy = 1'b1;
        if (tlp.valid && tlp.last) begin
          state_next = IDLE;
          drop_inc   = 1'b1;
        end
      end

      FLUSH_DLLP: begin
        dllp_rdy = 1'b1;
        if (dllp.valid && dllp.last) begin
          state_next = IDLE;
          drop_inc   = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, DLLP run counter and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      run_reg      <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
      if (drop_inc && (drop_cnt_reg != 8'hFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  // Output register: loads on an owner handshake, empties on out_ready, and
  // is dropped outright when the link goes down.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_dk_reg    <= '0;
      out_last_reg  <= 1'b0;
    end else if (!linkup) begin
      out_valid_reg <= 1'b0;
    end else if (load_en) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= load_dllp ? dllp.data : tlp.data;
      out_dk_reg    <= load_dllp ? dllp.dk   : tlp.dk;
      out_last_reg  <= load_dllp ? dllp.last : tlp.last;
    end else if (out.ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Grant is a decode of the registered state, so it is glitch-free.
  always_comb begin
    grant = 2'b00;
    case (state_reg)
      GNT_TLP, FLUSH_TLP:   grant = 2'b01;
      GNT_DLLP, FLUSH_DLLP: grant = 2'b10;
      default:              grant = 2'b00;
    endcase
  end

  assign tlp.ready  = tlp_rdy;
  assign dllp.ready = dllp_rdy;
  assign out.valid  = out_valid_reg;
  assign out.data   = out_data_reg;
  assign out.dk     = out_dk_reg;
  assign out.last   = out_last_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_pl_tx_arbiter.sv
// Directed bench for pl_tx_arbiter: basic transfer, DLLP run limit,
// backpressure, link loss, reset mid-packet and drop counter saturation.
module tb_pl_tx_arbiter;
  localparam int DATA_W = 512;
  localparam int DK_W   = 64;

  logic       clk;
  logic       rst;
  logic       linkup;
  logic [1:0] grant;
  logic [7:0] drop_cnt;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  pl_tx_arbiter_if #(.DATA_W(DATA_W), .DK_W(DK_W)) tlp_if ();
  pl_tx_arbiter_if #(.DATA_W(DATA_W), .DK_W(DK_W)) dllp_if ();
  pl_tx_arbiter_if #(.DATA_W(DATA_W), .DK_W(DK_W)) out_if ();

  pl_tx_arbiter #(.DATA_W(DATA_W), .DK_W(DK_W), .MAX_DLLP_RUN(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .linkup   (linkup),
    .tlp      (tlp_if),
    .dllp     (dllp_if),
    .out      (out_if),
    .grant    (grant),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_tlp(input logic v, input logic [7:0] b, input logic l);
    tlp_if.valid = v;
    tlp_if.data  = {64{b}};
    tlp_if.dk    = {8{b}};
    tlp_if.last  = l;
  endtask

  task automatic drive_dllp(input logic v, input logic [7:0] b, input logic l);
    dllp_if.valid = v;
    dllp_if.data  = {64{b}};
    dllp_if.dk    = {8{b}};
    dllp_if.last  = l;
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [7:0] b);
    return {64{b}};
  endfunction

  logic [1:0] t2_exp [10];

  initial begin
    t2_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    rst = 1'b1;
    linkup = 1'b0;
    out_if.ready = 1'b0;
    drive_tlp(1'b0, 8'h00, 1'b0);
    drive_dllp(1'b0, 8'h00, 1'b0);
    nxt();
    nxt();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_out_data", out_if.data, 0);
    chk("rst_out_last", out_if.last, 0);
    chk("rst_grant", grant, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_tlp_ready", tlp_if.ready, 0);
    chk("rst_dllp_ready", dllp_if.ready, 0);

    // Test 1: 3-beat TLP with out_ready held high
    linkup = 1'b1;
    out_if.ready = 1'b1;
    drive_tlp(1'b1, 8'hA1, 1'b0);
    #1 chk("t1_idle_ready", tlp_if.ready, 0);
    nxt();
    chk("t1_grant", grant, 2'b01);
    chk("t1_tlp_ready", tlp_if.ready, 1);
    chk("t1_out_valid_pre", out_if.valid, 0);
    nxt();
    chk("t1_b1_valid", out_if.valid, 1);
    chk("t1_b1_data", out_if.data, pat(8'hA1));
    chk("t1_b1_dk", out_if.dk, {8{8'hA1}});
    chk("t1_b1_last", out_if.last, 0);
    drive_tlp(1'b1, 8'hA2, 1'b0);
    nxt();
    chk("t1_b2_valid", out_if.valid, 1);
    chk("t1_b2_data", out_if.data, pat(8'hA2));
    chk("t1_b2_last", out_if.last, 0);
    drive_tlp(1'b1, 8'hA3, 1'b1);
    nxt();
    chk("t1_b3_valid", out_if.valid, 1);
    chk("t1_b3_data", out_if.data, pat(8'hA3));
    chk("t1_b3_last", out_if.last, 1);
    chk("t1_grant_end", grant, 2'b00);
    drive_tlp(1'b0, 8'h00, 1'b0);
    nxt();
    chk("t1_out_valid_end", out_if.valid, 0);

    // Test 2: DLLP run limit with both requesters always valid
    drive_tlp(1'b1, 8'hB0, 1'b1);
    drive_dllp(1'b1, 8'hC0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      nxt();
      chk($sformatf("t2_grant_%0d", i), grant, t2_exp[i]);
      chk($sformatf("t2_nonowner_ready_%0d", i),
          (t2_exp[i] == 2'b10) ? tlp_if.ready : dllp_if.ready, 0);
      nxt();
      chk($sformatf("t2_bubble_%0d", i), grant, 2'b00);
    end
    drive_tlp(1'b0, 8'h00, 1'b0);

    // Test 3: 2-beat DLLP with a 3-cycle stall after the first beat
    drive_dllp(1'b1, 8'hD1, 1'b0);
    nxt();
    chk("t3_grant", grant, 2'b10);
    chk("t3_ready", dllp_if.ready, 1);
    nxt();
    chk("t3_b1_data", out_if.data, pat(8'hD1));
    drive_dllp(1'b1, 8'hD2, 1'b1);
    out_if.ready = 1'b0;
    #1 chk("t3_stall_ready0", dllp_if.ready, 0);
    for (int k = 0; k < 2; k++) begin
      nxt();
      chk($sformatf("t3_stall_valid_%0d", k), out_if.valid, 1);
      chk($sformatf("t3_stall_data_%0d", k), out_if.data, pat(8'hD1));
      chk($sformatf("t3_stall_ready_%0d", k), dllp_if.ready, 0);
    end
    nxt();
    chk("t3_stall_data_2", out_if.data, pat(8'hD1));
    out_if.ready = 1'b1;
    #1 chk("t3_release_ready", dllp_if.ready, 1);
    nxt();
    chk("t3_b2_valid", out_if.valid, 1);
    chk("t3_b2_data", out_if.data, pat(8'hD2));
    chk("t3_b2_last", out_if.last, 1);
    chk("t3_grant_end", grant, 2'b00);
    drive_dllp(1'b0, 8'h00, 1'b0);
    nxt();
    chk("t3_out_valid_end", out_if.valid, 0);

    // Test 4: link loss after beat 2 of a 4-beat TLP
    drive_tlp(1'b1, 8'hE1, 1'b0);
    nxt();
    chk("t4_grant", grant, 2'b01);
    nxt();
    chk("t4_b1_data", out_if.data, pat(8'hE1));
    drive_tlp(1'b1, 8'hE2, 1'b0);
    nxt();
    chk("t4_b2_valid", out_if.valid, 1);
    chk("t4_b2_data", out_if.data, pat(8'hE2));
    drive_tlp(1'b1, 8'hE3, 1'b0);
    linkup = 1'b0;
    out_if.ready = 1'b0;
    #1 chk("t4_down_ready", tlp_if.ready, 1);
    nxt();
    chk("t4_out_valid_cleared", out_if.valid, 0);
    chk("t4_flush_grant", grant, 2'b01);
    chk("t4_drop_before", drop_cnt, 0);
    drive_tlp(1'b1, 8'hE4, 1'b1);
    drive_dllp(1'b1, 8'hC5, 1'b1);
    #1 chk("t4_flush_ready", tlp_if.ready, 1);
    chk("t4_flush_nonowner", dllp_if.ready, 0);
    nxt();
    chk("t4_drop_after", drop_cnt, 1);
    chk("t4_grant_idle", grant, 2'b00);
    chk("t4_out_valid_idle", out_if.valid, 0);
    chk("t4_idle_tlp_ready", tlp_if.ready, 0);
    nxt();
    chk("t4_no_grant_a", grant, 2'b00);
    nxt();
    chk("t4_no_grant_b", grant, 2'b00);
    chk("t4_drop_hold", drop_cnt, 1);
    drive_tlp(1'b0, 8'h00, 1'b0);
    drive_dllp(1'b0, 8'h00, 1'b0);
    linkup = 1'b1;
    out_if.ready = 1'b1;
    nxt();

    // Test 5: reset during beat 2 of a 3-beat DLLP
    drive_dllp(1'b1, 8'h51, 1'b0);
    nxt();
    chk("t5_grant", grant, 2'b10);
    nxt();
    chk("t5_b1_data", out_if.data, pat(8'h51));
    drive_dllp(1'b1, 8'h52, 1'b0);
    rst = 1'b1;
    nxt();
    chk("t5_rst_out_valid", out_if.valid, 0);
    chk("t5_rst_grant", grant, 2'b00);
    chk("t5_rst_drop", drop_cnt, 0);
    chk("t5_rst_dllp_ready", dllp_if.ready, 0);
    rst = 1'b0;
    drive_dllp(1'b0, 8'h00, 1'b0);
    drive_tlp(1'b1, 8'h61, 1'b1);
    nxt();
    chk("t5_new_grant", grant, 2'b01);
    chk("t5_new_ready", tlp_if.ready, 1);
    nxt();
    chk("t5_new_valid", out_if.valid, 1);
    chk("t5_new_data", out_if.data, pat(8'h61));
    chk("t5_new_last", out_if.last, 1);
    chk("t5_new_drop", drop_cnt, 0);

    // Test 6: 260 single-beat TLPs dropped on link loss
    drive_tlp(1'b1, 8'h77, 1'b1);
    for (int i = 0; i < 260; i++) begin
      nxt();
      linkup = 1'b0;
      nxt();
      chk($sformatf("t6_drop_%0d", i), drop_cnt, (i + 1 > 255) ? 255 : i + 1);
      linkup = 1'b1;
    end
    drive_tlp(1'b0, 8'h00, 1'b0);
    chk("t6_out_valid", out_if.valid, 0);
    nxt();
    chk("t6_drop_final", drop_cnt, 255);
    chk("t6_grant_final", grant, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
